synapse_fanout_unit: RTL and testbench

Upstream stage of `lif_neuron_array`: converts each incoming axon spike into one weighted event per target neuron by walking that axon's row of a synaptic weight memory. Events leave on an AXI-Stream-style interface that connects directly to the LIF array spike input (`s_axis_spike_*`). Weights are loaded through a simple write port driven by the AXI-Lite config block.

---
 rtl/snn_pkg.sv | 17 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/synapse_fanout_unit.sv | 185 ++++++++++++++++++
 tb/tb_synapse_fanout_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN datapath: fan-out FSM states and weight-word layout.
// A weight word is {exc_inh, magnitude[WEIGHT_WIDTH-1:0]}.
package snn_pkg;

   typedef enum logic [1:0] {
      FANOUT_IDLE = 2'd0,
      FANOUT_READ = 2'd1,
      FANOUT_EMIT = 2'd2,
      FANOUT_WAIT = 2'd3
   } fanout_state_t;

   // The excitatory/inhibitory flag sits directly above the magnitude field.
   function automatic int unsigned w_exc_bit(input int unsigned weight_width);
      return weight_width;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head read (first-word fall-through).
// Push is ignored when full and pop is ignored when empty; DEPTH must be a power of 2.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/synapse_fanout_unit.sv
// Expands each queued axon spike into one weighted event per destination neuron.
// Optional build macro: SKIP_ZERO_WEIGHT_EN suppresses events whose weight magnitude is zero.
module synapse_fanout_unit
   import snn_pkg::*;
#(
   parameter int unsigned NUM_AXONS       = 64,
   parameter int unsigned NUM_NEURONS     = 64,
   parameter int unsigned WEIGHT_WIDTH    = 8,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned AXON_ID_WIDTH   = $clog2(NUM_AXONS),
   parameter int unsigned NEURON_ID_WIDTH = $clog2(NUM_NEURONS)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   enable,
   input  logic                                   s_axis_axon_valid,
   input  logic [AXON_ID_WIDTH-1:0]               s_axis_axon_id,
   output logic                                   s_axis_axon_ready,
   output logic                                   m_axis_spike_valid,
   output logic [NEURON_ID_WIDTH-1:0]             m_axis_spike_dest_id,
   output logic [WEIGHT_WIDTH-1:0]                m_axis_spike_weight,
   output logic                                   m_axis_spike_exc_inh,
   input  logic                                   m_axis_spike_ready,
   input  logic                                   cfg_we,
   input  logic [AXON_ID_WIDTH+NEURON_ID_WIDTH-1:0] cfg_addr,
   input  logic [WEIGHT_WIDTH:0]                  cfg_data,
   output logic [31:0]                            axon_count,
   output logic [31:0]                            event_count,
   output logic                                   busy
);

   localparam int unsigned WORD_W    = WEIGHT_WIDTH + 1;
   localparam int unsigned W_EXC_BIT = w_exc_bit(WEIGHT_WIDTH);
   localparam int unsigned MEM_DEPTH = NUM_AXONS * NUM_NEURONS;
   localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);

   fanout_state_t state, state_next;

   logic                       fifo_empty;
   logic                       fifo_full;
   logic [AXON_ID_WIDTH-1:0]   fifo_head;
   logic                       axon_in_range;
   logic                       push;
   logic                       pop;

   logic [AXON_ID_WIDTH-1:0]   cfg_axon;
   logic [NEURON_ID_WIDTH-1:0] cfg_neuron;
   logic                       cfg_axon_ok;
   logic                       cfg_neuron_ok;

   logic [WORD_W-1:0]          wmem [MEM_DEPTH];
   logic [WORD_W-1:0]          rdata;
   logic [MEM_AW-1:0]          rd_idx;
   logic [MEM_AW-1:0]          wr_idx;

   logic [AXON_ID_WIDTH-1:0]   cur_axon;
   logic [NEURON_ID_WIDTH-1:0] nidx;
   logic                       last_neuron;
   logic                       skip_entry;
   logic                       rd_en;
   logic                       load_out;
   logic                       accept_out;
   logic                       advance;

   function automatic logic [MEM_AW-1:0] mem_index(input logic [AXON_ID_WIDTH-1:0]   a,
                                                   input logic [NEURON_ID_WIDTH-1:0] n);
      return MEM_AW'(a) * MEM_AW'(NUM_NEURONS) + MEM_AW'(n);
   endfunction

   // Range checks collapse to constants when the id field exactly spans the parameter.
   if (NUM_AXONS == 2 ** AXON_ID_WIDTH) begin : g_axon_full
      assign axon_in_range = 1'b1;
      assign cfg_axon_ok   = 1'b1;
   end else begin : g_axon_part
      assign axon_in_range = (s_axis_axon_id < AXON_ID_WIDTH'(NUM_AXONS));
      assign cfg_axon_ok   = (cfg_axon < AXON_ID_WIDTH'(NUM_AXONS));
   end

   if (NUM_NEURONS == 2 ** NEURON_ID_WIDTH) begin : g_neuron_full
      assign cfg_neuron_ok = 1'b1;
   end else begin : g_neuron_part
      assign cfg_neuron_ok = (cfg_neuron < NEURON_ID_WIDTH'(NUM_NEURONS));
   end

   assign s_axis_axon_ready = !fifo_full;
   assign push              = s_axis_axon_valid && !fifo_full && axon_in_range;

   sync_fifo #(
      .WIDTH (AXON_ID_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_axon_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (s_axis_axon_id),
      .pop       (pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign cfg_axon   = cfg_addr[AXON_ID_WIDTH+NEURON_ID_WIDTH-1:NEURON_ID_WIDTH];
   assign cfg_neuron = cfg_addr[NEURON_ID_WIDTH-1:0];
   assign wr_idx     = mem_index(cfg_axon, cfg_neuron);
   assign rd_idx     = mem_index(cur_axon, nidx);

   // Read-first block RAM; contents survive reset.
   always_ff @(posedge clk) begin
      if (cfg_we && cfg_axon_ok && cfg_neuron_ok) wmem[wr_idx] <= cfg_data;
      if (rd_en) rdata <= wmem[rd_idx];
   end

`ifdef SKIP_ZERO_WEIGHT_EN
   assign skip_entry = (rdata[WEIGHT_WIDTH-1:0] == '0);
`else
   assign skip_entry = 1'b0;
`endif

   assign last_neuron = (nidx == NEURON_ID_WIDTH'(NUM_NEURONS - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= FANOUT_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         FANOUT_IDLE: if (enable && !fifo_empty) state_next = FANOUT_READ;
         FANOUT_READ: state_next = FANOUT_EMIT;
         FANOUT_EMIT: begin
            if (!skip_entry)      state_next = FANOUT_WAIT;
            else if (last_neuron) state_next = FANOUT_IDLE;
            else                  state_next = FANOUT_READ;
         end
         FANOUT_WAIT: begin
            if (m_axis_spike_ready) state_next = last_neuron ? FANOUT_IDLE : FANOUT_READ;
         end
         default: state_next = FANOUT_IDLE;
      endcase
   end

   always_comb begin
      pop        = (state == FANOUT_IDLE) && enable && !fifo_empty;
      rd_en      = (state == FANOUT_READ);
      load_out   = (state == FANOUT_EMIT) && !skip_entry;
      accept_out = (state == FANOUT_WAIT) && m_axis_spike_ready;
      advance    = ((state == FANOUT_EMIT) && skip_entry) || accept_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_axon             <= '0;
         nidx                 <= '0;
         m_axis_spike_valid   <= 1'b0;
         m_axis_spike_dest_id <= '0;
         m_axis_spike_weight  <= '0;
         m_axis_spike_exc_inh <= 1'b0;
         axon_count           <= '0;
         event_count          <= '0;
      end else begin
         if (pop) begin
            cur_axon <= fifo_head;
            nidx     <= '0;
         end
         if (load_out) begin
            m_axis_spike_valid   <= 1'b1;
            m_axis_spike_dest_id <= nidx;
            m_axis_spike_weight  <= rdata[WEIGHT_WIDTH-1:0];
            m_axis_spike_exc_inh <= rdata[W_EXC_BIT];
         end
         if (accept_out) begin
            m_axis_spike_valid <= 1'b0;
            event_count        <= event_count + 32'd1;
         end
         if (advance) begin
            if (last_neuron) axon_count <= axon_count + 32'd1;
            else             nidx       <= nidx + NEURON_ID_WIDTH'(1);
         end
      end
   end

   assign busy = (state != FANOUT_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_synapse_fanout_unit.sv
// Directed + randomized bench for synapse_fanout_unit, using NUM_AXONS=70 so out-of-range ids exist.
// Expected events come from a per-axon row model; honours SKIP_ZERO_WEIGHT_EN like the design.
module tb_synapse_fanout_unit;

   localparam int NA = 70;
   localparam int NN = 64;
   localparam int WW = 8;
   localparam int AW = 7;
   localparam int NW = 6;

   typedef struct packed {
      logic [NW-1:0] dest;
      logic [WW-1:0] weight;
      logic          exc;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          s_axis_axon_valid;
   logic [AW-1:0] s_axis_axon_id;
   logic          s_axis_axon_ready;
   logic          m_axis_spike_valid;
   logic [NW-1:0] m_axis_spike_dest_id;
   logic [WW-1:0] m_axis_spike_weight;
   logic          m_axis_spike_exc_inh;
   logic          m_axis_spike_ready;
   logic          cfg_we;
   logic [AW+NW-1:0] cfg_addr;
   logic [WW:0]   cfg_data;
   logic [31:0]   axon_count;
   logic [31:0]   event_count;
   logic          busy;

   always #5 clk = ~clk;

   synapse_fanout_unit #(
      .NUM_AXONS       (NA),
      .NUM_NEURONS     (NN),
      .WEIGHT_WIDTH    (WW),
      .FIFO_DEPTH      (4),
      .AXON_ID_WIDTH   (AW),
      .NEURON_ID_WIDTH (NW)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .enable               (enable),
      .s_axis_axon_valid    (s_axis_axon_valid),
      .s_axis_axon_id       (s_axis_axon_id),
      .s_axis_axon_ready    (s_axis_axon_ready),
      .m_axis_spike_valid   (m_axis_spike_valid),
      .m_axis_spike_dest_id (m_axis_spike_dest_id),
      .m_axis_spike_weight  (m_axis_spike_weight),
      .m_axis_spike_exc_inh (m_axis_spike_exc_inh),
      .m_axis_spike_ready   (m_axis_spike_ready),
      .cfg_we               (cfg_we),
      .cfg_addr             (cfg_addr),
      .cfg_data             (cfg_data),
      .axon_count           (axon_count),
      .event_count          (event_count),
      .busy                 (busy)
   );

   logic [WW:0] wmem [NA][NN];
   ev_t exp_q[$];
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  last_hs = 0;
   int  exp_axons = 0;
   int  exp_events = 0;
   bit  rand_ready = 0;
   bit  check_gap = 0;
   bit  pend = 0;
   ev_t pend_ev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Model: an accepted in-range axon yields its row, ascending neuron order.
   task automatic enqueue_row(input int a);
      ev_t e;
      for (int n = 0; n < NN; n++) begin
`ifdef SKIP_ZERO_WEIGHT_EN
         if (wmem[a][n][WW-1:0] == '0) continue;
`endif
         e.dest   = NW'(n);
         e.weight = wmem[a][n][WW-1:0];
         e.exc    = wmem[a][n][WW];
         exp_q.push_back(e);
         exp_events++;
      end
      exp_axons++;
   endtask

   // One clock: sample at the falling edge, return 1 time unit after the rising edge.
   task automatic cycle();
      ev_t e;
      if (rand_ready) m_axis_spike_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!rst) begin
         if (s_axis_axon_valid && s_axis_axon_ready && (int'(s_axis_axon_id) < NA))
            enqueue_row(int'(s_axis_axon_id));
         if (pend) begin
            check("hold_valid", 32'(m_axis_spike_valid), 1);
            check("hold_dest", 32'(m_axis_spike_dest_id), 32'(pend_ev.dest));
            check("hold_weight", 32'(m_axis_spike_weight), 32'(pend_ev.weight));
            check("hold_exc", 32'(m_axis_spike_exc_inh), 32'(pend_ev.exc));
         end
         if (m_axis_spike_valid && m_axis_spike_ready) begin
            check("event_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("ev_dest", 32'(m_axis_spike_dest_id), 32'(e.dest));
               check("ev_weight", 32'(m_axis_spike_weight), 32'(e.weight));
               check("ev_exc", 32'(m_axis_spike_exc_inh), 32'(e.exc));
               if (check_gap && e.dest != '0) check("ev_gap", 32'(cyc - last_hs), 3);
            end
            last_hs = cyc;
         end
         pend = m_axis_spike_valid && !m_axis_spike_ready;
         pend_ev.dest   = m_axis_spike_dest_id;
         pend_ev.weight = m_axis_spike_weight;
         pend_ev.exc    = m_axis_spike_exc_inh;
      end else begin
         pend = 0;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int a, input int n, input logic [WW:0] d);
      cfg_we   = 1'b1;
      cfg_addr = {AW'(a), NW'(n)};
      cfg_data = d;
      cycle();
      cfg_we   = 1'b0;
      wmem[a][n] = d;
   endtask

   task automatic send_axon(input int id, input int budget);
      int k = 0;
      bit acc = 0;
      s_axis_axon_valid = 1'b1;
      s_axis_axon_id    = AW'(id);
      while (!acc && k < budget) begin
         acc = s_axis_axon_ready;
         cycle();
         k++;
      end
      s_axis_axon_valid = 1'b0;
      check($sformatf("send_%0d_accepted", id), 32'(acc), 1);
   endtask

   task automatic drain(input string tag, input int budget);
      int k = 0;
      while ((exp_q.size() != 0 || busy) && k < budget) begin
         cycle();
         k++;
      end
      check({tag, "_drained"}, 32'(k < budget), 1);
      for (int i = 0; i < 4; i++) cycle();
      check({tag, "_axon_count"}, axon_count, 32'(exp_axons));
      check({tag, "_event_count"}, event_count, 32'(exp_events));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int ev0;
      int id;
      logic [WW:0] d;

      rst = 1'b1; enable = 1'b1; s_axis_axon_valid = 1'b0; s_axis_axon_id = '0;
      m_axis_spike_ready = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      for (int i = 0; i < 3; i++) cycle();
      check("rst_valid", 32'(m_axis_spike_valid), 0);
      check("rst_dest", 32'(m_axis_spike_dest_id), 0);
      check("rst_weight", 32'(m_axis_spike_weight), 0);
      check("rst_exc", 32'(m_axis_spike_exc_inh), 0);
      check("rst_axon_ready", 32'(s_axis_axon_ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_axon_count", axon_count, 0);
      check("rst_event_count", event_count, 0);
      rst = 1'b0;

      // Random weights everywhere, roughly a quarter with zero magnitude.
      for (int a = 0; a < NA; a++)
         for (int n = 0; n < NN; n++) begin
            d[WW] = 1'($urandom_range(0, 1));
            d[WW-1:0] = ($urandom_range(0, 3) == 0) ? '0 : WW'($urandom_range(1, 255));
            cfg_write(a, n, d);
         end
      for (int n = 0; n < NN; n++) cfg_write(3, n, {1'b1, WW'(n + 1)});
      for (int n = 0; n < NN; n++) cfg_write(5, n, (n == 7) ? {1'b0, 8'd20} : '0);
      for (int n = 0; n < NN; n++) cfg_write(20, n, {1'($urandom_range(0, 1)), WW'($urandom_range(1, 255))});

      // Axon 3: latency, throughput and full row contents.
      m_axis_spike_ready = 1'b1;
      s_axis_axon_valid = 1'b1; s_axis_axon_id = AW'(3);
      check("t1_ready", 32'(s_axis_axon_ready), 1);
      cycle();
      s_axis_axon_valid = 1'b0;
      check("lat_e0", 32'(m_axis_spike_valid), 0);
      cycle(); check("lat_e1", 32'(m_axis_spike_valid), 0);
      cycle(); check("lat_e2", 32'(m_axis_spike_valid), 0);
      cycle(); check("lat_e3", 32'(m_axis_spike_valid), 1);
      check_gap = 1;
      drain("t1", 1000);
      check_gap = 0;
      check("t1_axons", axon_count, 1);
      check("t1_events", event_count, 64);

      // Axon 5: single non-zero entry.
      ev0 = int'(event_count);
      send_axon(5, 10);
      drain("t2", 1000);
`ifdef SKIP_ZERO_WEIGHT_EN
      check("t2_row_events", event_count - 32'(ev0), 1);
`else
      check("t2_row_events", event_count - 32'(ev0), 64);
`endif

      // Back-to-back axons with the output stalled.
      m_axis_spike_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_axis_axon_valid = 1'b1; s_axis_axon_id = AW'(10 + i);
         check($sformatf("bp_ready_%0d", i), 32'(s_axis_axon_ready), 1);
         cycle();
      end
      s_axis_axon_id = AW'(15);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp_full_%0d", i), 32'(s_axis_axon_ready), 0);
         cycle();
      end
      s_axis_axon_valid = 1'b0;
      rand_ready = 1;
      drain("bp", 8000);
      rand_ready = 0; m_axis_spike_ready = 1'b1;

      // No pop while enable is low.
      enable = 1'b0;
      send_axon(7, 10);
      for (int i = 0; i < 6; i++) begin
         cycle();
         check($sformatf("en_hold_valid_%0d", i), 32'(m_axis_spike_valid), 0);
         check($sformatf("en_hold_busy_%0d", i), 32'(busy), 1);
      end
      enable = 1'b1;
      drain("en", 1000);

      // Out-of-range ids are accepted and dropped.
      ev0 = int'(axon_count);
      send_axon(70, 10);
      send_axon(99, 10);
      send_axon(127, 10);
      check("discard_busy", 32'(busy), 0);
      drain("discard", 100);
      check("discard_axons", axon_count, 32'(ev0));

      // Randomized axons with random backpressure.
      rand_ready = 1;
      for (int r = 0; r < 10; r++) begin
         id = $urandom_range(0, 90);
         send_axon(id, 3000);
         k = $urandom_range(0, 40);
         for (int i = 0; i < k; i++) cycle();
      end
      drain("rand", 20000);
      rand_ready = 0; m_axis_spike_ready = 1'b1;

      // Reset while an event is waiting for acceptance.
      send_axon(20, 10);
      k = 0;
      while (event_count < 2 && k < 2000) begin cycle(); k++; end
      m_axis_spike_ready = 1'b0;
      k = 0;
      while (!m_axis_spike_valid && k < 500) begin cycle(); k++; end
      check("rst_mid_in_wait", 32'(m_axis_spike_valid), 1);
      rst = 1'b1;
      exp_q.delete(); exp_axons = 0; exp_events = 0;
      cycle();
      check("rst_mid_valid", 32'(m_axis_spike_valid), 0);
      check("rst_mid_axon_ready", 32'(s_axis_axon_ready), 1);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_axon_count", axon_count, 0);
      check("rst_mid_event_count", event_count, 0);
      rst = 1'b0;
      m_axis_spike_ready = 1'b1;
      send_axon(20, 10);
      drain("post_rst", 1000);
      check("post_rst_axons", axon_count, 1);
      check("post_rst_events", event_count, 64);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
